// File: rtl/rf_tx_gen_pkg.sv
// ============================================================================
// rf_tx_gen_pkg : packet framing constants shared by generator and checker
// Rev 1.0
// ============================================================================
`default_nettype none

package rf_tx_gen_pkg;

  localparam int         c_payload_len_def = 12;
  localparam int         c_err_period_def  = 16;
  localparam logic [7:0] c_chk_inv         = 8'hFF;

  localparam logic [3:0] c_st_idle = 4'b0001;
  localparam logic [3:0] c_st_data = 4'b0010;
  localparam logic [3:0] c_st_chk  = 4'b0100;
  localparam logic [3:0] c_st_gap  = 4'b1000;

  typedef enum logic [3:0] {
    ST_IDLE = c_st_idle,
    ST_DATA = c_st_data,
    ST_CHK  = c_st_chk,
    ST_GAP  = c_st_gap
  } state_t;

endpackage

`default_nettype wire

// File: rtl/rf_tx_gen.sv
// ============================================================================
// rf_tx_gen : fixed-length test packet generator (payload + XOR checksum)
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_tx_gen
  import rf_tx_gen_pkg::*;
#(
  parameter int PAYLOAD_LEN = c_payload_len_def,
  parameter int ERR_PERIOD  = c_err_period_def
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_tx_en,
  input  logic [15:0] i_pack_num,
  input  logic [15:0] i_gap_cyc,
  input  logic        i_err_inj_en,
  input  logic        i_fifo_full,
  input  logic        i_fifo_prog_full,
  output logic [7:0]  tx_data,
  output logic        tx_data_vld,
  output logic        o_busy,
  output logic [31:0] rf_tx_state
);

  localparam logic [7:0]  c_last_idx = 8'(PAYLOAD_LEN - 1);
  localparam logic [15:0] c_err_mask = 16'(ERR_PERIOD - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_byte_cnt;
  logic [7:0]  r_chk;
  logic [15:0] r_sess_cnt;
  logic [15:0] r_gap_cnt;
  logic [15:0] r_pack_total;
  logic [15:0] r_pack_err;

  logic        w_start;
  logic        w_inject;
  logic        w_data_wr;
  logic        w_chk_wr;
  logic        w_data_last;
  logic [7:0]  w_payload;

  assign w_start     = i_tx_en && !i_fifo_prog_full &&
                       ((i_pack_num == 16'd0) || (r_sess_cnt < i_pack_num));
  assign w_inject    = i_err_inj_en && ((r_pack_total & c_err_mask) == c_err_mask);
  assign w_data_wr   = (r_state == ST_DATA) && !i_fifo_full;
  assign w_chk_wr    = (r_state == ST_CHK) && !i_fifo_full;
  assign w_data_last = (r_byte_cnt == c_last_idx);
  assign w_payload   = r_pack_total[7:0] + r_byte_cnt;
  assign rf_tx_state = {r_pack_total, r_pack_err};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    tx_data     = 8'h00;
    tx_data_vld = 1'b0;
    o_busy      = (r_state != ST_IDLE);
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx_data     = w_payload;
        tx_data_vld = !i_fifo_full;
        if (w_data_wr && w_data_last) w_state_nxt = ST_CHK;
      end
      ST_CHK: begin
        tx_data     = w_inject ? (r_chk ^ c_chk_inv) : r_chk;
        tx_data_vld = !i_fifo_full;
        if (w_chk_wr) w_state_nxt = (i_gap_cyc != 16'd0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (r_gap_cnt == 16'd0) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_byte_cnt   <= 8'd0;
      r_chk        <= 8'd0;
      r_sess_cnt   <= 16'd0;
      r_gap_cnt    <= 16'd0;
      r_pack_total <= 16'd0;
      r_pack_err   <= 16'd0;
    end else begin
      if (w_data_wr) begin
        r_chk      <= r_chk ^ w_payload;
        r_byte_cnt <= w_data_last ? 8'd0 : r_byte_cnt + 8'd1;
      end
      if (w_chk_wr) begin
        r_chk        <= 8'd0;
        r_pack_total <= r_pack_total + 16'd1;
        r_sess_cnt   <= r_sess_cnt + 16'd1;
        if (w_inject) r_pack_err <= r_pack_err + 16'd1;
        // gap counter loads gap-1 so GAP lasts exactly i_gap_cyc cycles
        if (i_gap_cyc != 16'd0) r_gap_cnt <= i_gap_cyc - 16'd1;
      end
      if ((r_state == ST_GAP) && (r_gap_cnt != 16'd0)) begin
        r_gap_cnt <= r_gap_cnt - 16'd1;
      end
      if ((r_state == ST_IDLE) && !i_tx_en) begin
        r_sess_cnt <= 16'd0;
      end
    end
  end

endmodule

`default_nettype wire
